alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

- Multi-cycle execution unit that consumes the 3-bit `ALUControl` code produced by the ALU decoder, together with two 32-bit operands, and returns `ALUResult` and `Zero`.
- Sits in the execute stage of the RISC-V datapath.
- Add, sub, and, or, xor and slt complete in one cycle.
- sll and srl run on an iterative one-bit-per-cycle shifter; valid/ready handshakes on both sides let the controller stall.

## Interface
Parameters:
- `XLEN`, 32: operand/result width (only 32 is supported).
- `SHW`, 5: shift-amount width, always log2(XLEN).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request.
- `ALUControl` in 3: operation code. 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- `SrcA` in XLEN: first operand (value to shift for shifts).
- `SrcB` in XLEN: second operand. Bits [4:0] are the shift amount for shifts.
- `out_valid` out 1: `ALUResult`/`Zero` hold a valid result.
- `out_ready` in 1: consumer takes the result.
- `ALUResult` out XLEN: result, registered.
- `Zero` out 1: `ALUResult == 0`, registered with the result.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is in the package.
- Accept condition: `in_valid && in_ready`, where `in_ready = (state == IDLE)`. Operands and opcode are latched on acceptance; later input changes are ignored.
- IDLE, accept, non-shift op: compute with the combinational core, register the result, go to DONE.
- IDLE, accept, shift op with shamt = 0: register `SrcA` unchanged, go to DONE.
- IDLE, accept, shift op with shamt ≠ 0: load the shift register with `SrcA`, load the 5-bit down-counter with shamt, go to SHIFT.
- SHIFT: each cycle shift by one (sll: left, zero fill; srl: right, zero fill) and decrement the counter. When the counter goes 1→0, register the final value and go to DONE.
- DONE: `out_valid = 1`. On `out_ready`, go to IDLE. Otherwise hold `ALUResult`/`Zero` stable.
- Arithmetic: add/sub wrap modulo 2^32, with no overflow flag.
- slt is signed: result is `{31'b0, diff[31] ^ ovf}`, where `diff = SrcA - SrcB` and `ovf` is signed subtraction overflow.
- `Zero` is computed from the final registered result for every op, including shifts.
- All 8 codes are defined; there is no illegal-op path.
- Reset, at any time including mid-SHIFT or DONE:
  - state goes to IDLE, and `in_ready` is 1 once `rst_n` is high;
  - `out_valid`, `ALUResult`, `Zero`, the counter and the shift register all go to 0;
  - any in-flight operation is discarded.

## Timing
- Acceptance edge = k.
- Non-shift op, or shift with shamt 0: `out_valid` is high in the cycle after edge k (latency 1).
- Shift with shamt s > 0: `out_valid` rises after edge k+s (latency s+1, max 32).
- Handshake: the result transfers on the edge where `out_valid && out_ready`. `in_ready` rises the following cycle. There is no same-cycle issue from DONE; back-to-back throughput is one op per 2 cycles minimum.
- `in_ready` depends only on state, never combinationally on `out_ready`.
- `out_valid` stays high until consumed.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum with the 8 `ALUControl` codes (also imported by the decoder);
  - `alu_state_t` enum (IDLE, SHIFT, DONE);
  - `XLEN` and `SHW` constants.
- Sub-module `alu_comb`: purely combinational add/sub/and/or/xor/slt on XLEN-bit operands, instantiated once.
- The FSM, shifter and counter stay in `alu_exec_unit`.

## Test plan
- Add, `SrcA = 5`, `SrcB = 7`, `out_ready = 1` → `ALUResult = 12`, `Zero = 0`, `out_valid` one cycle after accept, `in_ready` back high the next cycle.
- Sub and slt:
  - sub `9 - 9` → 0, `Zero = 1`;
  - slt `0xFFFFFFFF` vs `0x00000001` → 1;
  - slt `0x7FFFFFFF` vs `0x80000000` → 0 (overflow case).
- Shifts:
  - sll `0x00000001` by 31 → `0x80000000`, `out_valid` after 32 cycles;
  - srl `0x80000000` by 4 → `0x08000000`, latency 5;
  - srl with `SrcB = 0x20` (shamt 0) → `SrcA` unchanged, latency 1.
- Backpressure: `out_ready = 0` for 3 cycles after `out_valid` → `ALUResult` and `Zero` unchanged, `in_ready = 0`, and a new `in_valid` request is not accepted. On `out_ready = 1` → transfer, then accept the pending request.
- Operand change: change `SrcA` during SHIFT → final result reflects the latched operand.
- Reset mid-shift: assert `rst_n = 0` asynchronously mid-clock, 3 cycles into sll by 20 → outputs 0 immediately, IDLE after release, no spurious `out_valid`, and the next add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU execution unit
// Purpose: ALUControl opcode enum (also used by the ALU decoder), execution
//          unit FSM state enum, datapath width constants, shift-op helper.
// Ports:   none (package).
package alu_pkg;

   localparam int XLEN = 32;
   localparam int SHW  = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } alu_state_t;

   function automatic logic is_shift(alu_op_t op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/result handshake bundle of the ALU execution unit
// Purpose: groups the request side (in_valid/in_ready, ALUControl, SrcA, SrcB)
//          and the result side (out_valid/out_ready, ALUResult, Zero).
// Modports:
//   master - the controller: drives requests and out_ready, reads results.
//   slave  - the execution unit: reads requests and out_ready, drives results.
interface alu_exec_unit_if;

   logic                     in_valid;
   logic                     in_ready;
   logic [2:0]               ALUControl;
   logic [alu_pkg::XLEN-1:0] SrcA;
   logic [alu_pkg::XLEN-1:0] SrcB;
   logic                     out_valid;
   logic                     out_ready;
   logic [alu_pkg::XLEN-1:0] ALUResult;
   logic                     Zero;

   modport master (
      output in_valid, ALUControl, SrcA, SrcB, out_ready,
      input  in_ready, out_valid, ALUResult, Zero
   );

   modport slave (
      input  in_valid, ALUControl, SrcA, SrcB, out_ready,
      output in_ready, out_valid, ALUResult, Zero
   );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle combinational ALU core
// Purpose: add/sub/and/or/xor/slt on XLEN-bit operands; shift codes give 0
//          because shifts are handled by the iterative shifter in the top.
// Ports:
//   a, b - operands
//   op   - ALUControl operation code
//   y    - combinational result
module alu_comb
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_t         op,
   output logic [XLEN-1:0] y
);

   logic [XLEN-1:0] diff;
   logic            ovf;

   assign diff = a - b;
   // Signed overflow of a - b: operands differ in sign and the result sign
   // differs from a. The true sign of the difference is then diff MSB ^ ovf.
   assign ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = diff;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_SLT: y = {{(XLEN-1){1'b0}}, diff[XLEN-1] ^ ovf};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execution unit with iterative shifter
// Purpose: one-cycle add/sub/and/or/xor/slt via alu_comb; sll/srl shift one
//          bit per cycle. Registered result with valid/ready on both sides.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_exec_unit_if.slave: in_valid/in_ready, ALUControl, SrcA,
//           SrcB, out_valid/out_ready, ALUResult, Zero
module alu_exec_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_exec_unit_if.slave   bus
);

   import alu_pkg::*;

   alu_state_t      state_q, state_d;
   alu_op_t         op_in;
   logic [XLEN-1:0] shreg_q, res_q, comb_y, shift_nxt;
   logic [SHW-1:0]  cnt_q, shamt;
   logic            sll_q, zero_q, accept;

   assign op_in  = alu_op_t'(bus.ALUControl);
   assign shamt  = bus.SrcB[SHW-1:0];
   assign accept = bus.in_valid && (state_q == ST_IDLE);

   // Direction is latched at acceptance so the live opcode is never consulted mid-shift.
   assign shift_nxt = sll_q ? {shreg_q[XLEN-2:0], 1'b0} : {1'b0, shreg_q[XLEN-1:1]};

   alu_comb u_comb (
      .a  (bus.SrcA),
      .b  (bus.SrcB),
      .op (op_in),
      .y  (comb_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_shift(op_in) && (shamt != '0)) state_d = ST_SHIFT;
               else                                  state_d = ST_DONE;
            end
         end
         ST_SHIFT: if (cnt_q == SHW'(1)) state_d = ST_DONE;
         ST_DONE:  if (bus.out_ready)    state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == ST_IDLE);
      bus.out_valid = (state_q == ST_DONE);
      bus.ALUResult = res_q;
      bus.Zero      = zero_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         sll_q   <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_shift(op_in)) begin
                     if (shamt == '0) begin
                        res_q  <= bus.SrcA;
                        zero_q <= (bus.SrcA == '0);
                     end else begin
                        shreg_q <= bus.SrcA;
                        cnt_q   <= shamt;
                        sll_q   <= (op_in == ALU_SLL);
                     end
                  end else begin
                     res_q  <= comb_y;
                     zero_q <= (comb_y == '0);
                  end
               end
            end
            ST_SHIFT: begin
               shreg_q <= shift_nxt;
               cnt_q   <= cnt_q - SHW'(1);
               // Last step: publish the shifted value together with its Zero flag.
               if (cnt_q == SHW'(1)) begin
                  res_q  <= shift_nxt;
                  zero_q <= (shift_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   alu_exec_unit_if bus ();

   alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op with out_ready held high; measure latency and check result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic zero,
                         input int lat, input logic scramble);
      int n;
      bus.out_ready  = 1'b1;
      bus.ALUControl = op;
      bus.SrcA       = a;
      bus.SrcB       = b;
      bus.in_valid   = 1'b1;
      chk({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (scramble) begin
         bus.SrcA       = 32'hFFFF_FFFF;
         bus.SrcB       = 32'h0;
         bus.ALUControl = 3'b000;
      end
      n = 1;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(lat));
      chk({tag, " ALUResult"}, bus.ALUResult, res);
      chk({tag, " Zero"}, 32'(bus.Zero), 32'(zero));
      @(posedge clk); #1;
      chk({tag, " in_ready after"}, 32'(bus.in_ready), 32'd1);
      chk({tag, " out_valid after"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int seen;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus.ALUControl = 3'b000;
      bus.SrcA       = '0;
      bus.SrcB       = '0;
      rst_n          = 1'b0;

      //            op      a              b              res            zero lat
      vecs.push_back('{3'd0, 32'd5,         32'd7,         32'd12,        1'b0, 1});
      vecs.push_back('{3'd1, 32'd9,         32'd9,         32'd0,         1'b1, 1});
      vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1,         1'b0, 1});
      vecs.push_back('{3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b1, 1});
      vecs.push_back('{3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0, 1});
      vecs.push_back('{3'd5, 32'd3,         32'd5,         32'd1,         1'b0, 1});
      vecs.push_back('{3'd5, 32'd5,         32'd3,         32'd0,         1'b1, 1});
      vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1});
      vecs.push_back('{3'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1});
      vecs.push_back('{3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1});
      vecs.push_back('{3'd3, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 1});
      vecs.push_back('{3'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1});
      vecs.push_back('{3'd6, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 32});
      vecs.push_back('{3'd7, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 5});
      vecs.push_back('{3'd7, 32'h1234_5678, 32'h20,        32'h1234_5678, 1'b0, 1});
      vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 1'b0, 32});
      vecs.push_back('{3'd6, 32'h0000_0000, 32'd3,         32'h0000_0000, 1'b1, 4});
      vecs.push_back('{3'd6, 32'h8000_0001, 32'd1,         32'h0000_0002, 1'b0, 2});

      // Reset state
      #12;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset ALUResult", bus.ALUResult, 32'd0);
      chk("reset Zero", 32'(bus.Zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].zero, vecs[i].lat, 1'b0);

      // Backpressure: hold out_ready low while a second request waits.
      bus.out_ready  = 1'b0;
      bus.ALUControl = 3'b000;
      bus.SrcA       = 32'd3;
      bus.SrcB       = 32'd4;
      bus.in_valid   = 1'b1;
      @(posedge clk); #1;
      bus.ALUControl = 3'b100;
      bus.SrcA       = 32'h0000_0066;
      bus.SrcB       = 32'h0000_0066;
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
         chk($sformatf("bp hold%0d ALUResult", c), bus.ALUResult, 32'd7);
         chk($sformatf("bp hold%0d Zero", c), 32'(bus.Zero), 32'd0);
         chk($sformatf("bp hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp transfer out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp transfer in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp pending out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp pending ALUResult", bus.ALUResult, 32'd0);
      chk("bp pending Zero", 32'(bus.Zero), 32'd1);
      @(posedge clk); #1;
      chk("bp pending drained", 32'(bus.out_valid), 32'd0);

      // Operand change during SHIFT must not affect the latched shift.
      run_op("opchg", 3'd6, 32'h0000_0003, 32'd5, 32'h0000_0060, 1'b0, 6, 1'b1);

      // Asynchronous reset three cycles into sll by 20.
      bus.ALUControl = 3'b110;
      bus.SrcA       = 32'h0000_0001;
      bus.SrcB       = 32'd20;
      bus.in_valid   = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst ALUResult", bus.ALUResult, 32'd0);
      chk("midrst Zero", 32'(bus.Zero), 32'd0);
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      chk("midrst spurious out_valid", 32'(seen), 32'd0);
      run_op("postrst add", 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
